l1_refill_arbiter: RTL and testbench

- Sequences cache-miss refills and shares the single main-memory port between the L1 instruction cache and the L1 data cache.
- Accepts one request at a time, forwards it to memory, and returns the response to the owning cache.
- Watchdog aborts a hung memory transaction and returns an error word.
- Sits between both L1 caches and the main-memory model/controller.

---
 rtl/l1_arb_pkg.sv | 6 +
 rtl/l1_refill_arbiter_if.sv | 39 +++
 rtl/l1_rr_arb2.sv | 23 ++
 rtl/l1_refill_arbiter.sv | 85 ++++++++
 tb/tb_l1_refill_arbiter.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/l1_arb_pkg.sv
// l1_arb_pkg: shared types and defaults for the L1 refill arbiter
package l1_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  typedef enum logic {OWN_IC, OWN_DC} owner_t;
  localparam logic [31:0] ERR_DATA_DEF = 32'hDEADBEEF;
endpackage

// File: rtl/l1_refill_arbiter_if.sv
// l1_refill_arbiter_if: cache-side and memory-side signals of the refill arbiter
interface l1_refill_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  ic_req_i;
  logic [ADDR_WIDTH-1:0] ic_addr_i;
  logic                  ic_gnt_o;
  logic                  ic_rvalid_o;
  logic [DATA_WIDTH-1:0] ic_rdata_o;
  logic                  dc_req_i;
  logic                  dc_we_i;
  logic [ADDR_WIDTH-1:0] dc_addr_i;
  logic [DATA_WIDTH-1:0] dc_wdata_i;
  logic                  dc_gnt_o;
  logic                  dc_rvalid_o;
  logic [DATA_WIDTH-1:0] dc_rdata_o;
  logic                  mem_req_o;
  logic                  mem_we_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic                  mem_ready_i;
  logic                  mem_rvalid_i;
  logic [DATA_WIDTH-1:0] mem_rdata_i;
  logic                  busy_o;
  logic                  err_o;
  modport master (
    input  ic_req_i, ic_addr_i, dc_req_i, dc_we_i, dc_addr_i, dc_wdata_i,
           mem_ready_i, mem_rvalid_i, mem_rdata_i,
    output ic_gnt_o, ic_rvalid_o, ic_rdata_o, dc_gnt_o, dc_rvalid_o, dc_rdata_o,
           mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, busy_o, err_o
  );
  modport slave (
    output ic_req_i, ic_addr_i, dc_req_i, dc_we_i, dc_addr_i, dc_wdata_i,
           mem_ready_i, mem_rvalid_i, mem_rdata_i,
    input  ic_gnt_o, ic_rvalid_o, ic_rdata_o, dc_gnt_o, dc_rvalid_o, dc_rdata_o,
           mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, busy_o, err_o
  );
endinterface

// File: rtl/l1_rr_arb2.sv
// l1_rr_arb2: two-way round-robin picker; a tie goes to whoever did not win last
module l1_rr_arb2
  import l1_arb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_req_ic,
  input  logic i_req_dc,
  output logic o_gnt_ic,
  output logic o_gnt_dc
);
  owner_t r_last;
  logic   w_pick_dc;
  always_comb begin
    w_pick_dc = i_req_dc && (!i_req_ic || r_last == OWN_IC);
    o_gnt_dc  = i_en && w_pick_dc;
    o_gnt_ic  = i_en && i_req_ic && !w_pick_dc;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_last <= OWN_IC;
    else if (o_gnt_ic || o_gnt_dc) r_last <= o_gnt_dc ? OWN_DC : OWN_IC;
endmodule

// File: rtl/l1_refill_arbiter.sv
// l1_refill_arbiter: shares one memory port between the L1 I- and D-caches,
// one transaction at a time, with a watchdog that answers hung requests with ERR_DATA.
module l1_refill_arbiter
  import l1_arb_pkg::*;
#(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    TIMEOUT_CYCLES = 64,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA       = DATA_WIDTH'(ERR_DATA_DEF)
) (
  input logic                 clk,
  input logic                 rst_n,
  l1_refill_arbiter_if.master bus
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  state_t                r_state, w_next;
  owner_t                r_owner;
  logic                  r_we, r_err;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata, r_ic_rdata, r_dc_rdata;
  logic [CW-1:0]         r_cnt;
  logic                  w_gnt_ic, w_gnt_dc, w_last, w_done, w_timeout;
  // grants are suppressed while reset is asserted so every output reads 0
  l1_rr_arb2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_en     (r_state == IDLE && rst_n),
    .i_req_ic (bus.ic_req_i),
    .i_req_dc (bus.dc_req_i),
    .o_gnt_ic (w_gnt_ic),
    .o_gnt_dc (w_gnt_dc)
  );
  assign w_last    = r_cnt == CW'(TIMEOUT_CYCLES - 1);
  assign w_done    = r_state == WAIT && bus.mem_rvalid_i;
  // the awaited event wins over the limit when both land in the same cycle
  assign w_timeout = w_last && ((r_state == ISSUE && !bus.mem_ready_i) ||
                                (r_state == WAIT && !bus.mem_rvalid_i));
  always_comb begin
    w_next          = r_state;
    bus.ic_gnt_o    = w_gnt_ic;
    bus.dc_gnt_o    = w_gnt_dc;
    bus.ic_rvalid_o = r_state == RESP && r_owner == OWN_IC;
    bus.dc_rvalid_o = r_state == RESP && r_owner == OWN_DC;
    bus.ic_rdata_o  = r_ic_rdata;
    bus.dc_rdata_o  = r_dc_rdata;
    bus.mem_req_o   = r_state == ISSUE;
    bus.mem_we_o    = r_state == ISSUE && r_we;
    bus.mem_addr_o  = r_state == ISSUE ? r_addr : '0;
    bus.mem_wdata_o = r_state == ISSUE ? r_wdata : '0;
    bus.busy_o      = r_state != IDLE;
    bus.err_o       = r_state == RESP && r_err;
    unique case (r_state)
      IDLE:    w_next = (w_gnt_ic || w_gnt_dc) ? ISSUE : IDLE;
      ISSUE:   w_next = bus.mem_ready_i ? WAIT : (w_timeout ? RESP : ISSUE);
      WAIT:    w_next = (w_done || w_timeout) ? RESP : WAIT;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state    <= IDLE;
      r_owner    <= OWN_IC;
      r_we       <= 1'b0;
      r_err      <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_cnt      <= '0;
      r_ic_rdata <= '0;
      r_dc_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_gnt_ic || w_gnt_dc) begin
        r_owner <= w_gnt_dc ? OWN_DC : OWN_IC;
        r_we    <= w_gnt_dc && bus.dc_we_i;
        r_addr  <= w_gnt_dc ? bus.dc_addr_i : bus.ic_addr_i;
        r_wdata <= bus.dc_wdata_i;
        r_cnt   <= '0;
      end else if ((r_state == ISSUE || r_state == WAIT) && !w_last) r_cnt <= r_cnt + CW'(1);
      if (w_done || w_timeout) begin
        r_err <= w_timeout;
        if (r_owner == OWN_IC) r_ic_rdata <= w_timeout ? ERR_DATA : bus.mem_rdata_i;
        else r_dc_rdata <= w_timeout ? ERR_DATA : bus.mem_rdata_i;
      end
    end
endmodule

// File: tb/tb_l1_refill_arbiter.sv
// tb_l1_refill_arbiter: directed stimulus with per-cache response scoreboards
module tb_l1_refill_arbiter;
  typedef struct packed {logic [31:0] d; logic e;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;
  exp_t ic_q[$];
  exp_t dc_q[$];
  always #5 clk = ~clk;
  l1_refill_arbiter_if bus ();
  l1_refill_arbiter #(.TIMEOUT_CYCLES(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic exp_t mk(logic [31:0] d, logic e);
    return {d, e};
  endfunction
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic serve(int rdly, int vdly, logic [31:0] d);
    bus.mem_ready_i = 1'b0;
    repeat (rdly) cyc();
    bus.mem_ready_i = 1'b1;
    cyc();
    bus.mem_ready_i = 1'b0;
    repeat (vdly) cyc();
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = d;
    cyc();
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = '0;
  endtask
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n) begin
      if (bus.ic_rvalid_o) begin
        if (ic_q.size() == 0) chk("ic_spurious_rvalid", 1, 0);
        else begin
          e = ic_q.pop_front();
          chk("ic_rdata", bus.ic_rdata_o, e.d);
          chk("ic_err", bus.err_o, e.e);
        end
      end
      if (bus.dc_rvalid_o) begin
        if (dc_q.size() == 0) chk("dc_spurious_rvalid", 1, 0);
        else begin
          e = dc_q.pop_front();
          chk("dc_rdata", bus.dc_rdata_o, e.d);
          chk("dc_err", bus.err_o, e.e);
        end
      end
      if (!bus.ic_rvalid_o && !bus.dc_rvalid_o) chk("err_without_rvalid", bus.err_o, 0);
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    logic exp_dc;
    logic [31:0] d;
    bus.ic_req_i = 1'b1; bus.ic_addr_i = '0;
    bus.dc_req_i = 1'b0; bus.dc_we_i = 1'b0; bus.dc_addr_i = '0; bus.dc_wdata_i = '0;
    bus.mem_ready_i = 1'b0; bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = '0;
    #1;
    chk("rst_ic_gnt", bus.ic_gnt_o, 0);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_mem_req", bus.mem_req_o, 0);
    chk("rst_ic_rdata", bus.ic_rdata_o, 0);
    chk("rst_dc_rdata", bus.dc_rdata_o, 0);
    bus.ic_req_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    // single icache read
    cyc();
    bus.ic_req_i = 1'b1; bus.ic_addr_i = 32'h0000_0100;
    #1;
    chk("t1_ic_gnt", bus.ic_gnt_o, 1);
    chk("t1_dc_gnt", bus.dc_gnt_o, 0);
    chk("t1_busy_at_gnt", bus.busy_o, 0);
    ic_q.push_back(mk(32'h0051_3093, 1'b0));
    cyc();
    bus.ic_req_i = 1'b0;
    #1;
    chk("t1_mem_req", bus.mem_req_o, 1);
    chk("t1_mem_addr", bus.mem_addr_o, 32'h0000_0100);
    chk("t1_mem_we", bus.mem_we_o, 0);
    chk("t1_busy_issue", bus.busy_o, 1);
    serve(0, 0, 32'h0051_3093);
    #1;
    chk("t1_ic_rvalid", bus.ic_rvalid_o, 1);
    chk("t1_dc_rvalid", bus.dc_rvalid_o, 0);
    chk("t1_dc_rdata", bus.dc_rdata_o, 0);
    chk("t1_busy_resp", bus.busy_o, 1);
    cyc();
    #1;
    chk("t1_busy_idle", bus.busy_o, 0);
    chk("t1_rvalid_pulse", bus.ic_rvalid_o, 0);
    chk("t1_rdata_held", bus.ic_rdata_o, 32'h0051_3093);
    // ties after reset alternate DC, IC, DC, IC
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    cyc();
    bus.ic_addr_i = 32'h100; bus.dc_addr_i = 32'h200; bus.dc_we_i = 1'b0;
    bus.ic_req_i = 1'b1; bus.dc_req_i = 1'b1;
    exp_dc = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("tie_dc_gnt", bus.dc_gnt_o, exp_dc);
      chk("tie_ic_gnt", bus.ic_gnt_o, !exp_dc);
      d = 32'h1111_0000 + 32'(i);
      if (exp_dc) dc_q.push_back(mk(d, 1'b0));
      else ic_q.push_back(mk(d, 1'b0));
      cyc();
      #1;
      chk("tie_mem_addr", bus.mem_addr_o, exp_dc ? 32'h200 : 32'h100);
      chk("tie_no_gnt_busy", bus.ic_gnt_o | bus.dc_gnt_o, 0);
      serve(0, 0, d);
      #1;
      chk("tie_no_gnt_resp", bus.ic_gnt_o | bus.dc_gnt_o, 0);
      cyc();
      exp_dc = !exp_dc;
    end
    bus.ic_req_i = 1'b0; bus.dc_req_i = 1'b0;
    // dcache write-back
    cyc();
    bus.dc_req_i = 1'b1; bus.dc_we_i = 1'b1; bus.dc_addr_i = 32'h1000; bus.dc_wdata_i = 32'hCAFE_F00D;
    #1;
    chk("wb_dc_gnt", bus.dc_gnt_o, 1);
    dc_q.push_back(mk(32'h0000_0A11, 1'b0));
    cyc();
    bus.dc_req_i = 1'b0; bus.dc_we_i = 1'b0;
    #1;
    chk("wb_mem_we", bus.mem_we_o, 1);
    chk("wb_mem_wdata", bus.mem_wdata_o, 32'hCAFE_F00D);
    chk("wb_mem_addr", bus.mem_addr_o, 32'h1000);
    serve(0, 1, 32'h0000_0A11);
    #1;
    chk("wb_dc_rvalid", bus.dc_rvalid_o, 1);
    chk("wb_ic_rvalid", bus.ic_rvalid_o, 0);
    chk("wb_mem_we_resp", bus.mem_we_o, 0);
    chk("wb_mem_wdata_resp", bus.mem_wdata_o, 0);
    cyc();
    // timeout in WAIT: ready given, rvalid never; a late rvalid is ignored
    cyc();
    bus.ic_req_i = 1'b1; bus.ic_addr_i = 32'h300;
    #1;
    chk("to_ic_gnt", bus.ic_gnt_o, 1);
    ic_q.push_back(mk(32'hDEAD_BEEF, 1'b1));
    cyc();
    bus.ic_req_i = 1'b0; bus.mem_ready_i = 1'b1;
    cyc();
    bus.mem_ready_i = 1'b0;
    repeat (7) begin
      #1;
      chk("to_wait_no_rvalid", bus.ic_rvalid_o, 0);
      cyc();
    end
    #1;
    chk("to_ic_rvalid", bus.ic_rvalid_o, 1);
    chk("to_err", bus.err_o, 1);
    chk("to_ic_rdata", bus.ic_rdata_o, 32'hDEAD_BEEF);
    bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h0BAD_0BAD;
    cyc();
    #1;
    chk("to_late_no_rvalid", bus.ic_rvalid_o, 0);
    chk("to_err_cleared", bus.err_o, 0);
    bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = '0;
    // rvalid on the final allowed cycle wins over the limit
    cyc();
    bus.ic_req_i = 1'b1; bus.ic_addr_i = 32'h304;
    #1;
    chk("edge_ic_gnt", bus.ic_gnt_o, 1);
    ic_q.push_back(mk(32'h600D_DA7A, 1'b0));
    cyc();
    bus.ic_req_i = 1'b0;
    serve(0, 6, 32'h600D_DA7A);
    #1;
    chk("edge_ic_rvalid", bus.ic_rvalid_o, 1);
    chk("edge_err", bus.err_o, 0);
    cyc();
    // timeout in ISSUE: ready never arrives
    cyc();
    bus.dc_req_i = 1'b1; bus.dc_we_i = 1'b0; bus.dc_addr_i = 32'h2000;
    #1;
    chk("toi_dc_gnt", bus.dc_gnt_o, 1);
    dc_q.push_back(mk(32'hDEAD_BEEF, 1'b1));
    cyc();
    bus.dc_req_i = 1'b0;
    repeat (8) begin
      #1;
      chk("toi_mem_req", bus.mem_req_o, 1);
      cyc();
    end
    #1;
    chk("toi_dc_rvalid", bus.dc_rvalid_o, 1);
    chk("toi_err", bus.err_o, 1);
    chk("toi_mem_req_off", bus.mem_req_o, 0);
    cyc();
    // backpressure; a dcache request waiting during the transaction is granted after RESP
    cyc();
    bus.ic_req_i = 1'b1; bus.ic_addr_i = 32'h400;
    #1;
    chk("bp_ic_gnt", bus.ic_gnt_o, 1);
    ic_q.push_back(mk(32'h4444_0400, 1'b0));
    cyc();
    bus.ic_req_i = 1'b0;
    bus.dc_req_i = 1'b1; bus.dc_addr_i = 32'h404; bus.dc_we_i = 1'b0;
    repeat (5) begin
      #1;
      chk("bp_mem_req", bus.mem_req_o, 1);
      chk("bp_mem_addr", bus.mem_addr_o, 32'h400);
      chk("bp_no_dc_gnt", bus.dc_gnt_o, 0);
      cyc();
    end
    serve(0, 0, 32'h4444_0400);
    #1;
    chk("bp_ic_rvalid", bus.ic_rvalid_o, 1);
    chk("bp_no_gnt_resp", bus.dc_gnt_o, 0);
    cyc();
    #1;
    chk("bp_dc_gnt_after", bus.dc_gnt_o, 1);
    dc_q.push_back(mk(32'h5555_0404, 1'b0));
    cyc();
    bus.dc_req_i = 1'b0;
    serve(1, 0, 32'h5555_0404);
    #1;
    chk("bp_dc_rvalid", bus.dc_rvalid_o, 1);
    cyc();
    // asynchronous reset in the middle of WAIT
    cyc();
    bus.ic_req_i = 1'b1; bus.ic_addr_i = 32'h500;
    #1;
    chk("rw_ic_gnt", bus.ic_gnt_o, 1);
    cyc();
    bus.ic_req_i = 1'b0; bus.mem_ready_i = 1'b1;
    cyc();
    bus.mem_ready_i = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rw_busy", bus.busy_o, 0);
    chk("rw_mem_req", bus.mem_req_o, 0);
    chk("rw_mem_addr", bus.mem_addr_o, 0);
    chk("rw_ic_rdata", bus.ic_rdata_o, 0);
    chk("rw_dc_rdata", bus.dc_rdata_o, 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h1234_5678;
    cyc();
    bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = '0;
    #1;
    chk("rw_late_ic_rvalid", bus.ic_rvalid_o, 0);
    chk("rw_late_busy", bus.busy_o, 0);
    chk("rw_ic_rdata_clear", bus.ic_rdata_o, 0);
    cyc();
    chk("ic_q_left", ic_q.size(), 0);
    chk("dc_q_left", dc_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
